// File: rtl/vc_allocator_pkg.sv
// Shared configuration and types for the VC allocator stage.
// Holds the port/VC counts, derived index widths and the request/state records.
package vc_allocator_pkg;

    localparam int NUM_BUFFERS  = 4;
    localparam int NUM_OUTPORTS = 4;
    localparam int NUM_VCS      = 2;

    // Index width for n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SELECT_SIZE = idx_width(NUM_BUFFERS);
    localparam int OUTPORT_W   = idx_width(NUM_OUTPORTS);
    localparam int VC_W        = idx_width(NUM_VCS);

    // One (egress port, VC) pair as chosen for a buffer.
    typedef struct packed {
        logic [OUTPORT_W-1:0] egress_port;
        logic [VC_W-1:0]      vc;
    } vc_req_t;

    // Reservation record kept for every output VC.
    typedef struct packed {
        logic                   busy;
        logic [SELECT_SIZE-1:0] owner;
    } vc_state_t;

endpackage

// File: rtl/vc_allocator_if.sv
// Bundle of request, SA-stage and release signals around the VC allocator.
// The allocator connects through the slave modport; buffers/SA/testbench use master.
interface vc_allocator_if;
    import vc_allocator_pkg::*;

    logic [NUM_BUFFERS-1:0]                req_valid;
    logic [NUM_BUFFERS-1:0][OUTPORT_W-1:0] req_egress_port;
    logic [NUM_BUFFERS-1:0][VC_W-1:0]      req_vc;
    logic [NUM_BUFFERS-1:0]                grant;
    logic                                  sa_valid;
    logic [SELECT_SIZE-1:0]                sa_ingress_port;
    logic [OUTPORT_W-1:0]                  sa_egress_port;
    logic [VC_W-1:0]                       sa_final_vc;
    logic                                  sa_failed;
    logic [SELECT_SIZE-1:0]                sa_failed_ingress;
    logic                                  release_valid;
    logic [OUTPORT_W-1:0]                  release_outport;
    logic [VC_W-1:0]                       release_vc;

    modport master (
        output req_valid, req_egress_port, req_vc,
        output sa_failed, sa_failed_ingress,
        output release_valid, release_outport, release_vc,
        input  grant, sa_valid, sa_ingress_port, sa_egress_port, sa_final_vc
    );

    modport slave (
        input  req_valid, req_egress_port, req_vc,
        input  sa_failed, sa_failed_ingress,
        input  release_valid, release_outport, release_vc,
        output grant, sa_valid, sa_ingress_port, sa_egress_port, sa_final_vc
    );

endinterface

// File: rtl/vc_allocator_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the pointer,
// and moves the pointer just past the winner whenever it grants and advance is set.
module vc_allocator_rr_arbiter
    import vc_allocator_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] ptr_q;

    // Scan requests cyclically from the pointer and take the first one found.
    always_comb begin
        int b;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        b       = 0;
        for (int k = 0; k < N; k++) begin
            b = (int'(ptr_q) + k) % N;
            if (!valid_o && req_i[b]) begin
                valid_o    = 1'b1;
                grant_o[b] = 1'b1;
                idx_o      = IW'(b);
            end
        end
    end

    // Pointer register: wraps to zero after the last requester wins.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else if (advance_i && valid_o) begin
            ptr_q <= (int'(idx_o) == N - 1) ? '0 : IW'(int'(idx_o) + 1);
        end
    end

endmodule

// File: rtl/vc_allocator.sv
// VC allocation stage ahead of the switch allocator. Reserves an output VC for
// one head-flit request per cycle and registers the winner into the SA stage.
// Define VC_REMAP_EN to let a request for a busy VC fall back to the
// lowest-index free VC on the same egress port.
module vc_allocator
    import vc_allocator_pkg::*;
(
    input logic           clk,
    input logic           n_rst,
    vc_allocator_if.slave bus
);

    vc_state_t              vc_q [NUM_OUTPORTS][NUM_VCS];
    vc_state_t              vc_d [NUM_OUTPORTS][NUM_VCS];
    logic [NUM_BUFFERS-1:0] pending_q;
    logic [NUM_BUFFERS-1:0] pending_d;

    logic [NUM_BUFFERS-1:0] eligible;
    logic [VC_W-1:0]        cand_vc [NUM_BUFFERS];
    logic [NUM_BUFFERS-1:0] arb_grant;
    logic [SELECT_SIZE-1:0] arb_idx;
    logic                   arb_valid;
    vc_req_t                win_req;

    logic [NUM_BUFFERS-1:0] grant_q;
    logic                   sa_valid_q;
    logic [SELECT_SIZE-1:0] sa_ingress_q;
    logic [OUTPORT_W-1:0]   sa_egress_q;
    logic [VC_W-1:0]        sa_vc_q;

    // Pick a candidate VC per buffer from the registered busy bits and qualify it.
    always_comb begin
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            cand_vc[i]  = bus.req_vc[i];
            eligible[i] = 1'b0;
            if (!vc_q[bus.req_egress_port[i]][bus.req_vc[i]].busy) begin
                eligible[i] = 1'b1;
            end
`ifdef VC_REMAP_EN
            else begin
                for (int v = NUM_VCS - 1; v >= 0; v--) begin
                    if (!vc_q[bus.req_egress_port[i]][VC_W'(v)].busy) begin
                        cand_vc[i]  = VC_W'(v);
                        eligible[i] = 1'b1;
                    end
                end
            end
`endif
            eligible[i] = eligible[i] & bus.req_valid[i] & ~pending_q[i];
        end
    end

    vc_allocator_rr_arbiter #(.N(NUM_BUFFERS)) u_arb (
        .clk       (clk),
        .n_rst     (n_rst),
        .req_i     (eligible),
        .advance_i (1'b1),
        .grant_o   (arb_grant),
        .idx_o     (arb_idx),
        .valid_o   (arb_valid)
    );

    assign win_req = '{egress_port: bus.req_egress_port[arb_idx], vc: cand_vc[arb_idx]};

    // Next VC table and pending bits: release and failure clears first, then the grant's sets.
    always_comb begin
        vc_d      = vc_q;
        pending_d = pending_q;
        if (bus.release_valid && vc_q[bus.release_outport][bus.release_vc].busy) begin
            vc_d[bus.release_outport][bus.release_vc].busy = 1'b0;
            pending_d[vc_q[bus.release_outport][bus.release_vc].owner] = 1'b0;
        end
        if (bus.sa_failed && pending_q[bus.sa_failed_ingress]) begin
            pending_d[bus.sa_failed_ingress] = 1'b0;
            for (int p = 0; p < NUM_OUTPORTS; p++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    if (vc_q[p][v].busy && vc_q[p][v].owner == bus.sa_failed_ingress) begin
                        vc_d[p][v].busy = 1'b0;
                    end
                end
            end
        end
        if (arb_valid) begin
            vc_d[win_req.egress_port][win_req.vc] = '{busy: 1'b1, owner: arb_idx};
            pending_d[arb_idx] = 1'b1;
        end
    end

    // VC ownership table and pending bits; reset drops every reservation.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int p = 0; p < NUM_OUTPORTS; p++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    vc_q[p][v] <= '0;
                end
            end
            pending_q <= '0;
        end else begin
            vc_q      <= vc_d;
            pending_q <= pending_d;
        end
    end

    // SA-stage output register; data fields hold their last winner when idle.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            grant_q      <= '0;
            sa_valid_q   <= 1'b0;
            sa_ingress_q <= '0;
            sa_egress_q  <= '0;
            sa_vc_q      <= '0;
        end else begin
            grant_q    <= arb_grant;
            sa_valid_q <= arb_valid;
            if (arb_valid) begin
                sa_ingress_q <= arb_idx;
                sa_egress_q  <= win_req.egress_port;
                sa_vc_q      <= win_req.vc;
            end
        end
    end

    assign bus.grant           = grant_q;
    assign bus.sa_valid        = sa_valid_q;
    assign bus.sa_ingress_port = sa_ingress_q;
    assign bus.sa_egress_port  = sa_egress_q;
    assign bus.sa_final_vc     = sa_vc_q;

endmodule

// File: tb/tb_vc_allocator.sv
// Scoreboard bench for vc_allocator: directed scenarios followed by random
// traffic, each cycle predicted by a behavioural model of the allocation rules.
module tb_vc_allocator;
    import vc_allocator_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    vc_allocator_if bus ();

    vc_allocator dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int cyc;
        int grant;
        int sa_valid;
        int ing;
        int eg;
        int vc;
    } exp_t;
    exp_t expq[$];

    // Stimulus for the next cycle
    logic s_nrst;
    bit   s_valid [NUM_BUFFERS];
    int   s_port  [NUM_BUFFERS];
    int   s_vc    [NUM_BUFFERS];
    bit   s_rel;
    int   s_rel_port, s_rel_vc;
    bit   s_fail;
    int   s_fail_ing;

    // Reference state
    bit m_busy    [NUM_OUTPORTS][NUM_VCS];
    int m_owner   [NUM_OUTPORTS][NUM_VCS];
    bit m_pending [NUM_BUFFERS];
    int m_rr;
    int m_ing, m_eg, m_vc;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // VC the buffer would receive this cycle, or -1 when none is free for it
    function automatic int modelCandidate(input int b);
        if (!m_busy[s_port[b]][s_vc[b]]) return s_vc[b];
`ifdef VC_REMAP_EN
        for (int v = 0; v < NUM_VCS; v++) begin
            if (!m_busy[s_port[b]][v]) return v;
        end
`endif
        return -1;
    endfunction

    task automatic applyStimulus();
        int win, wvc, c, b;
        bit fail_hit;
        exp_t e;
        @(posedge clk);
        #1;
        n_rst = s_nrst;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            bus.req_valid[i]       = s_valid[i];
            bus.req_egress_port[i] = OUTPORT_W'(s_port[i]);
            bus.req_vc[i]          = VC_W'(s_vc[i]);
        end
        bus.release_valid     = s_rel;
        bus.release_outport   = OUTPORT_W'(s_rel_port);
        bus.release_vc        = VC_W'(s_rel_vc);
        bus.sa_failed         = s_fail;
        bus.sa_failed_ingress = SELECT_SIZE'(s_fail_ing);

        e.cyc = cyc + 1;
        e.grant = 0;
        e.sa_valid = 0;
        if (!s_nrst) begin
            foreach (m_busy[p, v]) begin
                m_busy[p][v] = 0;
                m_owner[p][v] = 0;
            end
            foreach (m_pending[i]) m_pending[i] = 0;
            m_rr = 0; m_ing = 0; m_eg = 0; m_vc = 0;
        end else begin
            win = -1; wvc = 0;
            for (int k = 0; k < NUM_BUFFERS; k++) begin
                b = (m_rr + k) % NUM_BUFFERS;
                c = modelCandidate(b);
                if (win < 0 && s_valid[b] && !m_pending[b] && c >= 0) begin
                    win = b;
                    wvc = c;
                end
            end
            fail_hit = s_fail && m_pending[s_fail_ing];
            if (s_rel && m_busy[s_rel_port][s_rel_vc]) begin
                m_busy[s_rel_port][s_rel_vc] = 0;
                m_pending[m_owner[s_rel_port][s_rel_vc]] = 0;
            end
            if (fail_hit) begin
                foreach (m_busy[p, v]) begin
                    if (m_busy[p][v] && m_owner[p][v] == s_fail_ing) m_busy[p][v] = 0;
                end
                m_pending[s_fail_ing] = 0;
            end
            if (win >= 0) begin
                m_busy[s_port[win]][wvc] = 1;
                m_owner[s_port[win]][wvc] = win;
                m_pending[win] = 1;
                m_rr = (win + 1) % NUM_BUFFERS;
                m_ing = win; m_eg = s_port[win]; m_vc = wvc;
                e.grant = 1 << win;
                e.sa_valid = 1;
            end
        end
        e.ing = m_ing; e.eg = m_eg; e.vc = m_vc;
        expq.push_back(e);
    endtask

    // Monitor: compare every registered output against the queued prediction
    always @(negedge clk) begin
        exp_t e;
        while (expq.size() != 0 && expq[0].cyc <= cyc) begin
            e = expq.pop_front();
            checkOutput("grant",       32'(bus.grant),           32'(e.grant));
            checkOutput("sa_valid",    32'(bus.sa_valid),        32'(e.sa_valid));
            checkOutput("sa_ingress",  32'(bus.sa_ingress_port), 32'(e.ing));
            checkOutput("sa_egress",   32'(bus.sa_egress_port),  32'(e.eg));
            checkOutput("sa_final_vc", 32'(bus.sa_final_vc),     32'(e.vc));
        end
    end

    task automatic idle();
        s_nrst = 1'b1;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            s_valid[i] = 0; s_port[i] = 0; s_vc[i] = 0;
        end
        s_rel = 0; s_rel_port = 0; s_rel_vc = 0;
        s_fail = 0; s_fail_ing = 0;
    endtask

    task automatic setReq(input int b, input int port, input int vc);
        s_valid[b] = 1; s_port[b] = port; s_vc[b] = vc;
    endtask

    task automatic doReset();
        idle();
        s_nrst = 1'b0;
        applyStimulus();
        applyStimulus();
        idle();
    endtask

    initial begin
        idle();
        s_nrst = 1'b0;

        // Reset, then a single request from buffer 0 for (2,1)
        doReset();
        setReq(0, 2, 1);
        applyStimulus();
        @(negedge clk);
        checkOutput("reset_sa_valid", 32'(bus.sa_valid), 0);
        checkOutput("reset_grant", 32'(bus.grant), 0);
        idle();
        applyStimulus();
        @(negedge clk);
        checkOutput("first_grant", 32'(bus.grant), 1);
        checkOutput("first_sa_valid", 32'(bus.sa_valid), 1);
        checkOutput("first_egress", 32'(bus.sa_egress_port), 2);
        checkOutput("first_vc", 32'(bus.sa_final_vc), 1);

        // All four buffers request distinct free VCs and hold their requests
        doReset();
        for (int b = 0; b < NUM_BUFFERS; b++) setReq(b, b, 0);
        repeat (6) applyStimulus();
        idle();
        applyStimulus();

        // Buffers 1 and 3 collide on (0,0); 3 waits for the release
        doReset();
        setReq(1, 0, 0);
        setReq(3, 0, 0);
        applyStimulus();
        s_valid[1] = 0;
        repeat (3) applyStimulus();
        s_rel = 1; s_rel_port = 0; s_rel_vc = 0;
        applyStimulus();
        s_rel = 0;
        applyStimulus();
        @(negedge clk);
        checkOutput("no_bypass_sa_valid", 32'(bus.sa_valid), 0);
        applyStimulus();
        @(negedge clk);
        checkOutput("after_release_grant", 32'(bus.grant), 8);
        idle();
        applyStimulus();

        // SA failure frees buffer 2's VC and it re-competes
        doReset();
        setReq(2, 1, 1);
        applyStimulus();
        applyStimulus();
        s_fail = 1; s_fail_ing = 2;
        applyStimulus();
        s_fail = 0;
        applyStimulus();
        applyStimulus();
        @(negedge clk);
        checkOutput("regrant_ingress", 32'(bus.sa_ingress_port), 2);
        checkOutput("regrant_vc", 32'(bus.sa_final_vc), 1);
        idle();
        applyStimulus();

        // Idle release and failure for a non-pending ingress
        doReset();
        s_rel = 1; s_rel_port = 2; s_rel_vc = 0;
        s_fail = 1; s_fail_ing = 0;
        applyStimulus();
        idle();
        repeat (2) applyStimulus();

        // (3,0) held by buffer 1, buffer 0 asks for it
        doReset();
        setReq(1, 3, 0);
        applyStimulus();
        idle();
        setReq(0, 3, 0);
        applyStimulus();
        applyStimulus();
        @(negedge clk);
`ifdef VC_REMAP_EN
        checkOutput("remap_grant", 32'(bus.grant), 1);
        checkOutput("remap_vc", 32'(bus.sa_final_vc), 1);
`else
        checkOutput("stall_grant", 32'(bus.grant), 0);
`endif
        s_rel = 1; s_rel_port = 3; s_rel_vc = 0;
        applyStimulus();
        s_rel = 0;
        repeat (2) applyStimulus();
        idle();
        applyStimulus();

        // Random traffic
        for (int t = 0; t < 3000; t++) begin
            s_nrst = ($urandom_range(0, 199) != 0);
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                s_valid[b] = m_pending[b] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
                s_port[b]  = $urandom_range(0, NUM_OUTPORTS - 1);
                s_vc[b]    = $urandom_range(0, NUM_VCS - 1);
            end
            s_rel      = ($urandom_range(0, 2) == 0);
            s_rel_port = $urandom_range(0, NUM_OUTPORTS - 1);
            s_rel_vc   = $urandom_range(0, NUM_VCS - 1);
            s_fail     = ($urandom_range(0, 5) == 0);
            s_fail_ing = $urandom_range(0, NUM_BUFFERS - 1);
            applyStimulus();
        end

        idle();
        applyStimulus();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("queue_drain", 32'(expq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
